// File: rtl/aes_cbc_packer.sv
// Packs four 32-bit plaintext words into a 128-bit block and XORs it with the CBC chaining
// value (IV or fed-back ciphertext) before handing it to the AES core.
module aes_cbc_packer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               iv_load_i,
  input  logic [127:0]       iv_i,
  input  logic               word_valid_i,
  output logic               word_ready_o,
  input  logic [31:0]        word_data_i,
  input  logic               ct_valid_i,
  input  logic [127:0]       ct_data_i,
  output logic               blk_valid_o,
  input  logic               blk_ready_i,
  output logic [127:0]       blk_data_o,
  output logic [CNT_W-1:0]   blk_count_o,
  output logic               overrun_o
);

  typedef enum logic [1:0] {
    StFill      = 2'd0,
    StWaitChain = 2'd1,
    StSend      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         word_cnt_q, word_cnt_d;
  logic [127:0]       buf_q, buf_d;
  logic [127:0]       chain_q, chain_d;
  logic               chain_valid_q, chain_valid_d;
  logic [127:0]       blk_data_q, blk_data_d;
  logic [CNT_W-1:0]   blk_count_q, blk_count_d;
  logic               overrun_q, overrun_d;

  logic               word_hs;
  logic               blk_hs;
  logic               chain_load;
  logic [127:0]       chain_new;
  logic [127:0]       chain_use;
  logic [127:0]       packed_blk;

  assign word_ready_o = (state_q == StFill);
  assign blk_valid_o  = (state_q == StSend);
  assign blk_data_o   = blk_data_q;
  assign blk_count_o  = blk_count_q;
  assign overrun_o    = overrun_q;

  assign word_hs    = word_valid_i & word_ready_o;
  assign blk_hs     = blk_valid_o & blk_ready_i;
  assign chain_load = iv_load_i | ct_valid_i;
  // IV load wins over ciphertext feedback in the same cycle.
  assign chain_new  = iv_load_i ? iv_i : ct_data_i;
  // Freshest chaining value visible this edge, used when the block completes.
  assign chain_use  = chain_load ? chain_new : chain_q;

  // Insert the incoming word MSB-first at the slot selected by the word count.
  always_comb begin
    packed_blk = buf_q;
    unique case (word_cnt_q)
      2'd0:    packed_blk[127:96] = word_data_i;
      2'd1:    packed_blk[95:64]  = word_data_i;
      2'd2:    packed_blk[63:32]  = word_data_i;
      default: packed_blk[31:0]   = word_data_i;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    buf_d         = buf_q;
    chain_d       = chain_q;
    chain_valid_d = chain_valid_q;
    blk_data_d    = blk_data_q;
    blk_count_d   = blk_count_q;
    overrun_d     = overrun_q;

    if (ct_valid_i && chain_valid_q) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StFill: begin
        if (word_hs) begin
          buf_d      = packed_blk;
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            if (chain_load || chain_valid_q) begin
              blk_data_d = packed_blk ^ chain_use;
              state_d    = StSend;
            end else begin
              state_d = StWaitChain;
            end
          end
        end
      end
      StWaitChain: begin
        if (chain_load) begin
          blk_data_d = buf_q ^ chain_new;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (blk_hs) begin
          state_d       = StFill;
          word_cnt_d    = 2'd0;
          chain_valid_d = 1'b0;
          blk_count_d   = blk_count_q + CNT_W'(1);
        end
      end
      default: state_d = StFill;
    endcase

    // Applied after the handshake so feedback arriving on that same edge is kept.
    if (chain_load) begin
      chain_d       = chain_new;
      chain_valid_d = 1'b1;
    end

    if (clear_i) begin
      state_d       = StFill;
      word_cnt_d    = 2'd0;
      buf_d         = '0;
      chain_d       = '0;
      chain_valid_d = 1'b0;
      blk_data_d    = '0;
      blk_count_d   = '0;
      overrun_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StFill;
      word_cnt_q    <= 2'd0;
      buf_q         <= '0;
      chain_q       <= '0;
      chain_valid_q <= 1'b0;
      blk_data_q    <= '0;
      blk_count_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      buf_q         <= buf_d;
      chain_q       <= chain_d;
      chain_valid_q <= chain_valid_d;
      blk_data_q    <= blk_data_d;
      blk_count_q   <= blk_count_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_aes_cbc_packer.sv
// Directed bench for aes_cbc_packer using NIST CBC vectors and hand-computed blocks.
module tb_aes_cbc_packer;

  localparam int unsigned CNT_W = 16;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               clear_i;
  logic               iv_load_i;
  logic [127:0]       iv_i;
  logic               word_valid_i;
  logic               word_ready_o;
  logic [31:0]        word_data_i;
  logic               ct_valid_i;
  logic [127:0]       ct_data_i;
  logic               blk_valid_o;
  logic               blk_ready_i;
  logic [127:0]       blk_data_o;
  logic [CNT_W-1:0]   blk_count_o;
  logic               overrun_o;

  int checks = 0;
  int errors = 0;

  aes_cbc_packer #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .iv_load_i    (iv_load_i),
    .iv_i         (iv_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .word_data_i  (word_data_i),
    .ct_valid_i   (ct_valid_i),
    .ct_data_i    (ct_data_i),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_data_o   (blk_data_o),
    .blk_count_o  (blk_count_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put_word(input logic [31:0] w);
    checks++;
    if (word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL word_ready before word %h: got %b want 1", w, word_ready_o);
    end
    word_valid_i = 1'b1;
    word_data_i  = w;
    tick();
    word_valid_i = 1'b0;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv_load_i = 1'b1;
    iv_i      = v;
    tick();
    iv_load_i = 1'b0;
  endtask

  task automatic pulse_ct(input logic [127:0] v);
    ct_valid_i = 1'b1;
    ct_data_i  = v;
    tick();
    ct_valid_i = 1'b0;
  endtask

  // Waits (bounded) for blk_valid_o, then completes the handshake.
  task automatic take_block(input string name, input logic [127:0] exp_data);
    int n = 0;
    while (blk_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (blk_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s blk_valid timeout: got %b want 1", name, blk_valid_o);
    end
    checks++;
    if (blk_data_o !== exp_data) begin
      errors++;
      $display("FAIL %s blk_data: got %h want %h", name, blk_data_o, exp_data);
    end
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;
  endtask

  task automatic check_count(input string name, input logic [CNT_W-1:0] exp);
    checks++;
    if (blk_count_o !== exp) begin
      errors++;
      $display("FAIL %s blk_count: got %0d want %0d", name, blk_count_o, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (blk_valid_o !== 1'b0 || blk_data_o !== 128'h0 || blk_count_o !== '0 ||
        overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: got valid=%b data=%h count=%0d ovr=%b want 0/0/0/0",
               name, blk_valid_o, blk_data_o, blk_count_o, overrun_o);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset_during");
    #10;
    rst_i = 1'b0;
    tick();
    check_reset_outputs("reset_after");
    checks++;
    if (word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset word_ready: got %b want 1", word_ready_o);
    end
  endtask

  task automatic test_iv_block();
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    check_count("iv_block_before", 16'd0);
    put_word(32'h6bc1bee2);
    put_word(32'h2e409f96);
    put_word(32'he93d7e11);
    checks++;
    if (blk_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL iv_block early valid: got %b want 0", blk_valid_o);
    end
    put_word(32'h7393172a);
    // One-cycle minimum latency: valid right after the 4th word edge.
    checks++;
    if (blk_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL iv_block latency: got %b want 1", blk_valid_o);
    end
    take_block("iv_block", 128'h6bc0bce12a459991e134741a7f9e1925);
    check_count("iv_block_after", 16'd1);
  endtask

  task automatic test_wait_chain();
    put_word(32'hae2d8a57);
    put_word(32'h1e03ac9c);
    put_word(32'h9eb76fac);
    put_word(32'h45af8e51);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (word_ready_o !== 1'b0 || blk_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wait_chain hold: got ready=%b valid=%b want 0/0",
                 word_ready_o, blk_valid_o);
      end
      tick();
    end
    pulse_ct(128'h7649abac8119b246cee98e9b12e9197d);
    checks++;
    if (blk_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_chain release: got %b want 1", blk_valid_o);
    end
    take_block("wait_chain", 128'hd86421fb9f1a1eda505ee1375746972c);
    check_count("wait_chain_after", 16'd2);
  endtask

  task automatic test_stall();
    load_iv({128{1'b1}});
    put_word(32'h00000000);
    put_word(32'h11111111);
    put_word(32'h22222222);
    put_word(32'h33333333);
    word_valid_i = 1'b1;
    word_data_i  = 32'hdeadbeef;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (blk_valid_o !== 1'b1 || word_ready_o !== 1'b0 ||
          blk_data_o !== 128'hffffffffeeeeeeeeddddddddcccccccc) begin
        errors++;
        $display("FAIL stall cycle %0d: got valid=%b ready=%b data=%h want 1/0/%h", i,
                 blk_valid_o, word_ready_o, blk_data_o, 128'hffffffffeeeeeeeeddddddddcccccccc);
      end
      tick();
    end
    word_valid_i = 1'b0;
    take_block("stall", 128'hffffffffeeeeeeeeddddddddcccccccc);
    check_count("stall_after", 16'd3);
  endtask

  task automatic test_overrun();
    pulse_ct(128'h123456789abcdef0123456789abcdef0);
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun first pulse: got %b want 0", overrun_o);
    end
    pulse_ct(128'h0f0f0f0ff0f0f0f000000000ffffffff);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun second pulse: got %b want 1", overrun_o);
    end
    put_word(32'h11111111);
    put_word(32'h22222222);
    put_word(32'h33333333);
    put_word(32'h44444444);
    take_block("overrun", 128'h1e1e1e1ed2d2d2d233333333bbbbbbbb);
    check_count("overrun_after", 16'd4);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0 || blk_count_o !== '0 || word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL clear: got ovr=%b count=%0d ready=%b want 0/0/1",
               overrun_o, blk_count_o, word_ready_o);
    end
  endtask

  task automatic test_priority();
    iv_load_i  = 1'b1;
    iv_i       = 128'h00112233445566778899aabbccddeeff;
    ct_valid_i = 1'b1;
    ct_data_i  = {128{1'b1}};
    tick();
    iv_load_i  = 1'b0;
    ct_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) put_word(32'h0);
    take_block("priority", 128'h00112233445566778899aabbccddeeff);
    check_count("priority_after", 16'd1);
  endtask

  task automatic test_reset_mid();
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    put_word(32'hcafef00d);
    put_word(32'h01234567);
    rst_i = 1'b1;
    #2;
    check_reset_outputs("reset_mid_during");
    rst_i = 1'b0;
    #2;
    checks++;
    if (word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid word_ready: got %b want 1", word_ready_o);
    end
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    put_word(32'h6bc1bee2);
    put_word(32'h2e409f96);
    put_word(32'he93d7e11);
    put_word(32'h7393172a);
    take_block("reset_mid", 128'h6bc0bce12a459991e134741a7f9e1925);
    check_count("reset_mid_after", 16'd1);
  endtask

  initial begin
    rst_i        = 1'b1;
    clear_i      = 1'b0;
    iv_load_i    = 1'b0;
    iv_i         = '0;
    word_valid_i = 1'b0;
    word_data_i  = '0;
    ct_valid_i   = 1'b0;
    ct_data_i    = '0;
    blk_ready_i  = 1'b0;
    #3;
    test_reset();
    test_iv_block();
    test_wait_chain();
    test_stall();
    test_overrun();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
